fp_arith_sched: RTL and testbench
=================================

# fp_arith_sched

Sequential command front end for the combinational `fp_arith` adder/subtractor. It accepts FP32 add/sub commands on a valid/ready stream and drives the `fp_arith` operand/op_sel/en inputs from an issue register. It captures `data_o` one cycle later into a result FIFO and returns tagged results on a second valid/ready stream. It sits between the accelerator's instruction dispatch and the FP datapath, turning the bare combinational unit into a back-pressurable pipelined resource.

## Interface
- `DATA_WIDTH`, 32, operand/result width (IEEE-754 single); shared value from the common package.
- `TAG_WIDTH`, 4, width of the command tag returned with each result.
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: synchronous; discards the issue register and all FIFO contents.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op_sel` in 1: 0 = add, 1 = subtract (`data_1 - data_2`).
- `cmd_data_1`, `cmd_data_2` in DATA_WIDTH: operands.
- `cmd_tag` in TAG_WIDTH: opaque ID, returned unchanged.
- `arith_data_1`, `arith_data_2` out DATA_WIDTH: to `fp_arith`.
- `arith_op_sel` out 1: to `fp_arith`.
- `arith_en` out 1: to `fp_arith`.
- `arith_data_o` in DATA_WIDTH: from `fp_arith`, combinational from the arith_* outputs.
- `res_valid` out 1: result at FIFO head.
- `res_ready` in 1: result consumed when `res_valid && res_ready`.
- `res_data` out DATA_WIDTH: result value.
- `res_tag` out TAG_WIDTH: tag of the originating command.
- `res_exc` out 2: [0] infinity, [1] NaN; see Configuration.
- `busy` out 1: high in state RUN.

## Operation
- Issue register (`iss_valid`, operands, op_sel, tag) loads on command handshake and clears otherwise; at most one command in flight.
- `arith_en = iss_valid`. `arith_*` are driven from the issue register; they hold their last values when `iss_valid` is low.
- When `iss_valid` is set, `{arith_data_o, iss_tag, exc}` is pushed into the FIFO that cycle.
- Credit rule: `cmd_ready = !flush && (fifo_count + iss_valid < FIFO_DEPTH)`. This guarantees that a push never meets a full FIFO; no overflow path exists.
- FIFO behaviour:
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - `fifo_count` is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged. A pop on the same cycle as a push into an empty FIFO is impossible, since `res_valid` is low that cycle.
- `res_valid = (fifo_count != 0)`. Head fields are stable while `res_valid && !res_ready`.
- FSM states:
  - IDLE: no issue, FIFO empty. Enter RUN on a command handshake.
  - RUN: returns to IDLE when `!iss_valid && fifo_count == 0 && no handshake`, or when a pop leaves the FIFO empty with nothing issued.
  - FLUSH: entered from any state on `flush`. Lasts one cycle: `iss_valid`, pointers and count are cleared, `cmd_ready = 0`, `res_valid = 0`. Next state is IDLE.
- A `flush` coincident with a command handshake cannot occur (`cmd_ready` is low). A `flush` coincident with a pop drops that pop; the consumer must ignore it.

## Timing
- Reset values:
  - `cmd_ready = 1`, `res_valid = 0`, `busy = 0`, `arith_en = 0`.
  - `arith_data_1 = arith_data_2 = 0`, `arith_op_sel = 0`.
  - `res_data`, `res_tag` and `res_exc` read 0 (empty-FIFO head, storage cleared).
  - State is IDLE.
- Latency: handshake at cycle N; `arith_en` high in N+1; FIFO write at the end of N+1; `res_valid` high from N+2.
- Throughput: one command per cycle while `res_ready` stays high.
- Reset asserted mid-operation discards all in-flight and queued results immediately. It does not wait for the clock.

## Configuration
- `FP_ARITH_SCHED_EXC_EN` defined:
  - `res_exc[0]` is set when the result exponent is all ones and the mantissa is 0.
  - `res_exc[1]` is set when the exponent is all ones and the mantissa is nonzero.
  - The flags are stored per FIFO entry.
- Undefined: `res_exc` is tied to 2'b00 and the FIFO stores no exception bits.

## Structure
- The shared package holds:
  - `DATA_WIDTH`, plus `EXP_WIDTH` = 8 and `MAN_WIDTH` = 23.
  - The FSM state enum `{IDLE, RUN, FLUSH}`.
  - The result-entry struct `{data, tag, exc}`.
- One sub-module, `fp_res_fifo`: parameterised synchronous FIFO with count output. `fp_arith` stays external; it is instantiated beside this block by the integrating level.

## Test plan
- Add: `3f800000 + 3f000000`, tag 1 → `res_data = 3fc00000`, `res_tag = 1`, `res_valid` at handshake + 2 cycles.
- Mixed-sign add then subtract, back to back, tags 2 and 3:
  - `3c54fdf4 + bccccccd` → `bc449ba6`.
  - `3c54fdf4 - 3ccccccd` → `bc449ba6`.
  - Results appear in order on consecutive cycles.
- Backpressure:
  - Hold `res_ready = 0` and stream 6 commands.
  - `cmd_ready` drops after exactly 4 accepted (issue + FIFO credit).
  - Release `res_ready`: 4 results drain in order, then the remaining 2 are accepted.
- Flush with 3 results queued → `res_valid = 0` next cycle, `busy = 0`, `cmd_ready = 1` one cycle later; no stale result ever appears.
- `7f800000 + 3f800000` with `FP_ARITH_SCHED_EXC_EN` → `res_data = 7f800000`, `res_exc = 01`. `7fc00000 + 0` → `res_exc = 10`. With the macro undefined, both give `res_exc = 00`.
- Assert `rst_n` low asynchronously between clock edges with 2 results pending → all outputs take their reset values immediately.

Source files
------------

// File: rtl/fp_arith_sched_pkg.sv
// Shared types and constants for the fp_arith command scheduler.
// The optional exception flags are enabled by the FP_ARITH_SCHED_EXC_EN macro.
package fp_arith_sched_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned EXP_WIDTH     = 8;
  localparam int unsigned MAN_WIDTH     = 23;
  localparam int unsigned TAG_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } sched_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_WIDTH_DEF-1:0] tag;
    logic [1:0]               exc;
  } res_entry_t;

  // {nan, inf}; both need an all-ones exponent.
  function automatic logic [1:0] exc_flags(input logic [DATA_WIDTH-1:0] d);
    logic [EXP_WIDTH-1:0] e;
    logic [MAN_WIDTH-1:0] m;
    e = d[MAN_WIDTH +: EXP_WIDTH];
    m = d[MAN_WIDTH-1:0];
    return {(&e) & (|m), (&e) & ~(|m)};
  endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous result FIFO with occupancy count and synchronous clear.
// Storage is cleared by reset so an empty head reads zero.
module fp_res_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [PtrW:0]    count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fp_arith_sched.sv
// Valid/ready command front end for the combinational fp_arith unit with a tagged result FIFO.
// Define FP_ARITH_SCHED_EXC_EN to store and return per-result inf/NaN flags.
module fp_arith_sched
  import fp_arith_sched_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op_sel,
  input  logic [DATA_WIDTH-1:0] cmd_data_1,
  input  logic [DATA_WIDTH-1:0] cmd_data_2,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic [DATA_WIDTH-1:0] arith_data_1,
  output logic [DATA_WIDTH-1:0] arith_data_2,
  output logic                  arith_op_sel,
  output logic                  arith_en,
  input  logic [DATA_WIDTH-1:0] arith_data_o,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [TAG_WIDTH-1:0]  res_tag,
  output logic [1:0]            res_exc,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef FP_ARITH_SCHED_EXC_EN
  localparam int unsigned EntryW = DATA_WIDTH + TAG_WIDTH + 2;
`else
  localparam int unsigned EntryW = DATA_WIDTH + TAG_WIDTH;
`endif

  sched_state_e          state_q, state_d;
  logic                  hs, pop;
  logic [CntW-1:0]       fifo_count;
  logic [EntryW-1:0]     wr_entry, rd_entry;
  logic                  iss_valid_q;
  logic                  iss_op_sel_q;
  logic [DATA_WIDTH-1:0] iss_data_1_q, iss_data_2_q;
  logic [TAG_WIDTH-1:0]  iss_tag_q;

  // Issue slot plus FIFO occupancy never exceeds depth, so a push always has room.
  assign cmd_ready = !flush && (state_q != StFlush) &&
                     ((fifo_count + CntW'(iss_valid_q)) < CntW'(FIFO_DEPTH));
  assign hs        = cmd_valid && cmd_ready;
  assign res_valid = (fifo_count != '0) && (state_q != StFlush);
  assign pop       = res_valid && res_ready && !flush;
  assign busy      = (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q  <= 1'b0;
      iss_op_sel_q <= 1'b0;
      iss_data_1_q <= '0;
      iss_data_2_q <= '0;
      iss_tag_q    <= '0;
    end else begin
      iss_valid_q <= hs;
      if (hs) begin
        iss_op_sel_q <= cmd_op_sel;
        iss_data_1_q <= cmd_data_1;
        iss_data_2_q <= cmd_data_2;
        iss_tag_q    <= cmd_tag;
      end
    end
  end

  assign arith_en     = iss_valid_q;
  assign arith_op_sel = iss_op_sel_q;
  assign arith_data_1 = iss_data_1_q;
  assign arith_data_2 = iss_data_2_q;

`ifdef FP_ARITH_SCHED_EXC_EN
  assign wr_entry = {arith_data_o, iss_tag_q, exc_flags(arith_data_o)};
  assign {res_data, res_tag, res_exc} = rd_entry;
`else
  assign wr_entry = {arith_data_o, iss_tag_q};
  assign {res_data, res_tag} = rd_entry;
  assign res_exc = 2'b00;
`endif

  fp_res_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (iss_valid_q),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StRun;
      // Leave once nothing is in flight and the FIFO is empty after this cycle.
      StRun:   if (!hs && !iss_valid_q && ((fifo_count - CntW'(pop)) == '0)) state_d = StIdle;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StFlush;
  end

endmodule

// File: tb/tb_fp_arith_sched.sv
// Randomised self-checking bench for fp_arith_sched with a behavioural FP32 adder stub
// and an in-order scoreboard of outstanding commands.
module tb_fp_arith_sched;

  localparam int unsigned DEPTH = 4;
`ifdef FP_ARITH_SCHED_EXC_EN
  localparam bit ExcEn = 1'b1;
`else
  localparam bit ExcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, cmd_valid, cmd_ready, cmd_op_sel;
  logic [31:0] cmd_data_1, cmd_data_2, arith_data_1, arith_data_2, arith_data_o, res_data;
  logic [3:0]  cmd_tag, res_tag;
  logic        arith_op_sel, arith_en, res_valid, res_ready, busy;
  logic [1:0]  res_exc;

  always #5 clk = ~clk;

  fp_arith_sched #(
    .TAG_WIDTH  (4),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op_sel   (cmd_op_sel),
    .cmd_data_1   (cmd_data_1),
    .cmd_data_2   (cmd_data_2),
    .cmd_tag      (cmd_tag),
    .arith_data_1 (arith_data_1),
    .arith_data_2 (arith_data_2),
    .arith_op_sel (arith_op_sel),
    .arith_en     (arith_en),
    .arith_data_o (arith_data_o),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .res_exc      (res_exc),
    .busy         (busy)
  );

  // Behavioural FP32 add/sub via double precision, rounded to nearest-even.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) return 0.0;
    if (f[30:23] == 8'hff) d = {f[31], 11'h7ff, f[22:0], 29'd0};
    else                   d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          ef;
    d = $realtobits(r);
    if (d[62:52] == 11'h7ff) return (d[51:0] != 0) ? 32'h7fc00000 : {d[63], 8'hff, 23'd0};
    if (d[62:52] == 11'h000) return {d[63], 31'd0};
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) m = m + 25'd1;
    ef = int'(d[62:52]) - 896;
    if (m[24]) begin
      m  = m >> 1;
      ef = ef + 1;
    end
    if (ef >= 255) return {d[63], 8'hff, 23'd0};
    if (ef <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(ef), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
    return r2f(sub ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
  endfunction

  function automatic logic [1:0] exc_model(input logic [31:0] d);
    logic inf, nan;
    inf = (d[30:23] == 8'hff) && (d[22:0] == 0);
    nan = (d[30:23] == 8'hff) && (d[22:0] != 0);
    return ExcEn ? {nan, inf} : 2'b00;
  endfunction

  always_comb arith_data_o = fp_model(arith_data_1, arith_data_2, arith_op_sel);

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [31:0] a, b;
    logic        sub;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        last_cmd;
  int          n_checks = 0, n_errors = 0, cyc = 0;
  bit          last_hs = 0, flush_prev = 0, dut_hs = 0;
  logic [31:0] pop_data;
  logic [3:0]  pop_tag;
  logic [1:0]  pop_exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs to the scoreboard, then advance it across the edge.
  task automatic cycle(output bit hs, output bit pop);
    bit   exp_ready, exp_valid;
    exp_t e;
    #1;
    exp_ready = !flush && !flush_prev && (q.size() < DEPTH);
    exp_valid = !flush_prev && (q.size() != 0) && (q[0].acc + 2 <= cyc);
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(q.size() != 0));
    check("arith_en", 32'(arith_en), 32'(last_hs));
    if (last_hs) begin
      check("arith_data_1", arith_data_1, last_cmd.a);
      check("arith_data_2", arith_data_2, last_cmd.b);
      check("arith_op_sel", 32'(arith_op_sel), 32'(last_cmd.sub));
    end
    dut_hs = cmd_valid && cmd_ready;
    hs     = cmd_valid && exp_ready;
    pop    = res_ready && exp_valid && !flush;
    if (pop) begin
      pop_data = res_data;
      pop_tag  = res_tag;
      pop_exc  = res_exc;
      check("res_data", res_data, q[0].data);
      check("res_tag", 32'(res_tag), 32'(q[0].tag));
      check("res_exc", 32'(res_exc), 32'(exc_model(q[0].data)));
      void'(q.pop_front());
    end
    if (hs) begin
      e.a    = cmd_data_1;
      e.b    = cmd_data_2;
      e.sub  = cmd_op_sel;
      e.tag  = cmd_tag;
      e.data = fp_model(cmd_data_1, cmd_data_2, cmd_op_sel);
      e.acc  = cyc;
      q.push_back(e);
      last_cmd = e;
    end
    last_hs = hs;
    if (flush) q.delete();
    flush_prev = flush;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic sub, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
    cmd_valid  = 1'b1;
    cmd_op_sel = sub;
    cmd_data_1 = a;
    cmd_data_2 = b;
    cmd_tag    = t;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] d, input logic [3:0] t,
                          input logic [1:0] x);
    bit hs, pp, seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(hs, pp);
      if (pp) begin
        seen = 1;
        check({tag, "_data"}, pop_data, d);
        check({tag, "_tag"}, 32'(pop_tag), 32'(t));
        check({tag, "_exc"}, 32'(pop_exc), 32'(x));
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_arith_en"}, 32'(arith_en), 32'd0);
    check({tag, "_arith_d1"}, arith_data_1, 32'd0);
    check({tag, "_arith_d2"}, arith_data_2, 32'd0);
    check({tag, "_arith_op"}, 32'(arith_op_sel), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_res_tag"}, 32'(res_tag), 32'd0);
    check({tag, "_res_exc"}, 32'(res_exc), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  initial begin
    bit hs, pp, pending;
    int idx;
    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_op_sel = 1'b0;
    cmd_data_1 = '0; cmd_data_2 = '0; cmd_tag = '0; res_ready = 1'b0;
    #3;
    check_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single add, result two cycles after the handshake.
    res_ready = 1'b1;
    set_cmd(1'b0, 32'h3f800000, 32'h3f000000, 4'd1);
    cycle(hs, pp);
    cmd_valid = 1'b0;
    wait_pop("add", 32'h3fc00000, 4'd1, 2'b00);

    // Mixed-sign add then subtract, back to back.
    set_cmd(1'b0, 32'h3c54fdf4, 32'hbccccccd, 4'd2);
    cycle(hs, pp);
    set_cmd(1'b1, 32'h3c54fdf4, 32'h3ccccccd, 4'd3);
    cycle(hs, pp);
    cmd_valid = 1'b0;
    wait_pop("mix_add", 32'hbc449ba6, 4'd2, 2'b00);
    wait_pop("mix_sub", 32'hbc449ba6, 4'd3, 2'b00);

    // Backpressure: six commands against a stalled consumer.
    res_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (idx < 6) set_cmd(1'($urandom), rand_fp(), rand_fp(), 4'(8 + idx));
      else         cmd_valid = 1'b0;
      cycle(hs, pp);
      if (dut_hs) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd4);
    res_ready = 1'b1;
    for (int i = 0; i < 30 && (idx < 6 || q.size() != 0); i++) begin
      if (idx < 6) set_cmd(1'($urandom), rand_fp(), rand_fp(), 4'(8 + idx));
      else         cmd_valid = 1'b0;
      cycle(hs, pp);
      if (dut_hs) idx++;
    end
    cmd_valid = 1'b0;
    check("bp_all_accepted", 32'(idx), 32'd6);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Flush with three results queued.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b0, rand_fp(), rand_fp(), 4'(i));
      cycle(hs, pp);
    end
    cmd_valid = 1'b0;
    cycle(hs, pp);
    check("flush_pre_valid", 32'(res_valid), 32'd1);
    flush = 1'b1;
    cycle(hs, pp);
    flush = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(hs, pp);

    // Exception flags.
    set_cmd(1'b0, 32'h7f800000, 32'h3f800000, 4'd5);
    cycle(hs, pp);
    cmd_valid = 1'b0;
    wait_pop("inf", 32'h7f800000, 4'd5, ExcEn ? 2'b01 : 2'b00);
    set_cmd(1'b0, 32'h7fc00000, 32'h00000000, 4'd6);
    cycle(hs, pp);
    cmd_valid = 1'b0;
    wait_pop("nan", 32'h7fc00000, 4'd6, ExcEn ? 2'b10 : 2'b00);

    // Random traffic with occasional flushes.
    pending = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pending && $urandom_range(3) != 0) begin
        set_cmd(1'($urandom), rand_fp(), rand_fp(), 4'($urandom));
        pending = 1;
      end
      cmd_valid = pending;
      res_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(49) == 0);
      cycle(hs, pp);
      if (hs) pending = 0;
      flush = 1'b0;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(hs, pp);
    check("rand_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset between edges with two results pending.
    res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_cmd(1'b1, rand_fp(), rand_fp(), 4'(12 + i));
      cycle(hs, pp);
    end
    cmd_valid = 1'b0;
    cycle(hs, pp);
    cycle(hs, pp);
    check("arst_pending", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    q.delete();
    last_hs    = 0;
    flush_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(hs, pp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
